// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants, slot phase type and polarity helper for the digit scanner
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  // Maps an active-high "on" bit to the pin level for the given polarity.
  function automatic logic to_pol(input logic value, input logic active_low);
    return value ^ active_low;
  endfunction

endpackage

// File: rtl/scan_timebase.sv
// rtl/scan_timebase.sv - slot counter, digit index, blank/drive phase and frame strobes
module scan_timebase
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = $clog2(SCAN_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] idx,
  output phase_t     phase,
  output logic       frame_wrap,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_wrap;

  assign slot_wrap  = (slot_cnt == LAST);
  assign frame_wrap = slot_wrap && (idx == 2'd3);

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign phase = PH_DRIVE;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_VAL = CNT_W'(BLANK_CYCLES);
      assign phase = (slot_cnt < BLANK_VAL) ? PH_BLANK : PH_DRIVE;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      idx        <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (slot_wrap) begin
        slot_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - frame-snapshotted 4-digit 7-segment scan multiplexer with anti-ghost blanking
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SEG_W-1:0]      seg_first,
  input  logic [SEG_W-1:0]      seg_second,
  input  logic [SEG_W-1:0]      seg_third,
  input  logic [SEG_W-1:0]      seg_fourth,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_tick
);

  logic [1:0]                       idx;
  phase_t                           phase;
  logic                             frame_wrap;
  logic                             primed;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] snap;
  logic [NUM_DIGITS-1:0]            mask_snap;
  logic                             lit;
  logic [NUM_DIGITS-1:0]            an_raw;
  logic [SEG_W-1:0]                 seg_raw;
  logic [NUM_DIGITS-1:0]            an_nxt;
  logic [SEG_W-1:0]                 seg_nxt;

  scan_timebase #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .idx        (idx),
    .phase      (phase),
    .frame_wrap (frame_wrap),
    .frame_tick (frame_tick)
  );

  // Segments follow the anode decision so the bus is never driven with every digit off.
  always_comb begin
    lit     = (phase == PH_DRIVE) && enable && primed && !mask_snap[idx];
    an_raw  = '0;
    seg_raw = '0;
    if (lit) begin
      an_raw[idx] = 1'b1;
      seg_raw     = snap[idx];
    end
    for (int i = 0; i < NUM_DIGITS; i++) an_nxt[i] = to_pol(an_raw[i], AN_ACTIVE_LOW);
    for (int i = 0; i < SEG_W; i++) seg_nxt[i] = to_pol(seg_raw[i], SEG_ACTIVE_LOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      primed    <= 1'b0;
      snap      <= '0;
      mask_snap <= '1;
      an_out    <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_out   <= {SEG_W{SEG_ACTIVE_LOW}};
    end else begin
      primed <= 1'b1;
      // First edge after reset loads immediately rather than waiting a whole frame.
      if (!primed || frame_wrap) begin
        snap[0]   <= seg_first;
        snap[1]   <= seg_second;
        snap[2]   <= seg_third;
        snap[3]   <= seg_fourth;
        mask_snap <= blank_mask;
      end
      an_out  <= an_nxt;
      seg_out <= seg_nxt;
    end
  end

endmodule
